// File: rtl/gate_resp_if.sv
// Valid/ready stream of {a, b, y} triples from a gate under test to its response checker.
interface gate_resp_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_y;

    modport master (output in_valid, output in_a, output in_b, output in_y, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, input in_y, output in_ready);
endinterface

// File: rtl/gate_resp_checker.sv
// Response checker for an exhaustive bitwise-gate sweep: counts pass/fail, tracks order,
// captures the first mismatch. Define RESP_MISR_EN to add a 16-bit response signature.
module gate_resp_checker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NVEC  = 2 ** (2 * WIDTH),
    parameter int unsigned CW    = 2 * WIDTH + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op_sel,
    gate_resp_if.slave         bus,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      pass_cnt,
    output logic [CW-1:0]      fail_cnt,
    output logic               order_err,
    output logic               fail_seen,
    output logic [3*WIDTH-1:0] first_fail,
    output logic [15:0]        signature
);
    localparam logic [CW-1:0] NvecC   = CW'(NVEC);
    localparam logic [CW-1:0] LastIdx = CW'(NVEC - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic             ready_q;
    logic [CW-1:0]    idx_q;
    logic             res_v_q;
    logic             ord_bad_q;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    logic [WIDTH-1:0] exp_y;
    logic             accept;
    logic             mismatch;
    logic [CW-1:0]    total_next;

    assign bus.in_ready = ready_q;
    assign accept       = bus.in_valid & ready_q;

    always_comb begin
        exp_y = '0;
        unique case (op_q)
            3'd0:    exp_y = a_q & b_q;
            3'd1:    exp_y = a_q | b_q;
            3'd2:    exp_y = a_q ^ b_q;
            3'd3:    exp_y = ~(a_q & b_q);
            3'd4:    exp_y = ~(a_q | b_q);
            3'd5:    exp_y = ~(a_q ^ b_q);
            3'd6:    exp_y = ~a_q;
            default: exp_y = '0;
        endcase
    end

    // Reserved op has no defined gate, so every vector is a failure.
    assign mismatch   = (op_q == 3'd7) || (y_q != exp_y);
    assign total_next = pass_cnt + fail_cnt + CW'(1);

`ifdef RESP_MISR_EN
    logic [15:0] sig_q;
    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= 3'd0;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            idx_q      <= '0;
            res_v_q    <= 1'b0;
            ord_bad_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            y_q        <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            order_err  <= 1'b0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
`ifdef RESP_MISR_EN
            sig_q      <= 16'h0000;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StRun;
                        op_q       <= op_sel;
                        ready_q    <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        idx_q      <= '0;
                        res_v_q    <= 1'b0;
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        order_err  <= 1'b0;
                        fail_seen  <= 1'b0;
                        first_fail <= '0;
`ifdef RESP_MISR_EN
                        sig_q      <= 16'hFFFF;
`endif
                    end
                end
                StRun: begin
                    // Stage 1: register the accepted triple and its order check.
                    res_v_q <= accept;
                    if (accept) begin
                        a_q       <= bus.in_a;
                        b_q       <= bus.in_b;
                        y_q       <= bus.in_y;
                        ord_bad_q <= ({bus.in_a, bus.in_b} != idx_q[2*WIDTH-1:0]);
                        idx_q     <= idx_q + CW'(1);
                        if (idx_q == LastIdx) ready_q <= 1'b0;
                    end
                    // Stage 2: fold the registered result into the statistics.
                    if (res_v_q) begin
                        if (mismatch) begin
                            fail_cnt  <= fail_cnt + CW'(1);
                            fail_seen <= 1'b1;
                            if (!fail_seen) first_fail <= {a_q, b_q, y_q};
                        end else begin
                            pass_cnt <= pass_cnt + CW'(1);
                        end
                        if (ord_bad_q) order_err <= 1'b1;
`ifdef RESP_MISR_EN
                        sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                                 ^ 16'(y_q);
`endif
                        if (total_next == NvecC) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: full sweeps per op with stuck bits, swapped order,
// valid gaps, mid-sweep reset and (with RESP_MISR_EN) signature comparison.
module tb_gate_resp_checker;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = 2 * WIDTH + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [2:0]         op_sel = 3'd0;
    logic               busy, done, order_err, fail_seen;
    logic [CW-1:0]      pass_cnt, fail_cnt;
    logic [3*WIDTH-1:0] first_fail;
    logic [15:0]        signature;
    logic [15:0]        m_sig;
    logic [15:0]        sig_a;
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 ready_leaks = 0;

    gate_resp_if #(.WIDTH(WIDTH)) bus ();

    gate_resp_checker #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_sel     (op_sel),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .order_err  (order_err),
        .fail_seen  (fail_seen),
        .first_fail (first_fail),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gate_y(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return 4'h0;
        endcase
    endfunction

    task automatic pulse_start(input logic [2:0] op);
        op_sel = op;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        m_sig  = 16'hFFFF;
    endtask

    // mode: 0 clean, 1 y[0] stuck-at-0, 2 vectors 5/6 swapped
    task automatic run_sweep(input logic [2:0] op, input int mode, input int gap_pct,
                             input int n_acc, input int flip_k, input bit mid_start);
        int k = 0;
        int cyc = 0;
        int v;
        logic rdy;
        logic [7:0] vb;
        logic [3:0] y;
        pulse_start(op);
        while (k < n_acc && cyc < 4000) begin
            v  = (mode == 2 && k == 5) ? 6 : (mode == 2 && k == 6) ? 5 : k;
            vb = 8'(v);
            y  = gate_y(op, vb[7:4], vb[3:0]);
            if (mode == 1) y[0] = 1'b0;
            if (k == flip_k) y[1] = ~y[1];
            bus.in_a     = vb[7:4];
            bus.in_b     = vb[3:0];
            bus.in_y     = y;
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            if (mid_start && k == 50) begin
                start  = 1'b1;
                op_sel = 3'd7;
            end
            rdy = bus.in_ready;
            if (rdy && !busy) ready_leaks++;
            @(posedge clk); #1;
            start = 1'b0;
            if (bus.in_valid && rdy) begin
                k++;
                m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {12'h0, y};
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        check_eq("sweep_accepts", k, n_acc);
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("done_reached", done, 1);
        check_eq("busy_after_done", busy, 0);
    endtask

    task automatic check_sig(input string tag);
`ifdef RESP_MISR_EN
        check_eq(tag, signature, m_sig);
`else
        check_eq(tag, signature, 16'h0000);
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_y = '0;
        #12;
        check_eq("rst_ready", bus.in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass_cnt, 0);
        check_eq("rst_fail", fail_cnt, 0);
        check_eq("rst_flags", {order_err, fail_seen}, 0);
        check_eq("rst_first", first_fail, 0);
        check_eq("rst_sig", signature, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Valid while idle must be dropped.
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq("idle_drop", pass_cnt + fail_cnt, 0);

        // NAND clean sweep with exact done timing.
        run_sweep(3'd3, 0, 0, 256, -1, 1'b0);
        check_eq("t1_ready_drop", bus.in_ready, 0);
        check_eq("t1_done_early", done, 0);
        check_eq("t1_busy_early", busy, 1);
        @(posedge clk); #1;
        check_eq("t1_done", done, 1);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_pass", pass_cnt, 256);
        check_eq("t1_fail", fail_cnt, 0);
        check_eq("t1_flags", {order_err, fail_seen}, 0);
        check_sig("t1_sig");

        // Done is held and further valids are dropped.
        bus.in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq("done_hold", done, 1);
        check_eq("done_drop", pass_cnt, 256);

        // NAND with y[0] stuck-at-0: bit0 of NAND is 1 for 3/4 of vectors.
        run_sweep(3'd3, 1, 0, 256, -1, 1'b0);
        wait_done();
        check_eq("t2_fail", fail_cnt, 192);
        check_eq("t2_pass", pass_cnt, 64);
        check_eq("t2_seen", fail_seen, 1);
        check_eq("t2_first", first_fail, 12'h00E);
        check_eq("t2_order", order_err, 0);

        // AND with 5/6 swapped, plus an ignored start mid-run.
        pulse_start(3'd0);
        check_eq("restart_clears", {fail_seen, 9'(fail_cnt)}, 0);
        run_sweep(3'd0, 2, 0, 256, -1, 1'b1);
        wait_done();
        check_eq("t3_order", order_err, 1);
        check_eq("t3_pass", pass_cnt, 256);
        check_eq("t3_fail", fail_cnt, 0);

        // XOR with ~50% valid gaps.
        run_sweep(3'd2, 0, 50, 256, -1, 1'b0);
        wait_done();
        check_eq("t4_pass", pass_cnt, 256);
        check_eq("t4_fail", fail_cnt, 0);
        check_eq("t4_order", order_err, 0);
        check_eq("t4_ready_leaks", ready_leaks, 0);
        check_sig("t4_sig");

        // Reserved op fails every vector.
        run_sweep(3'd7, 0, 0, 256, -1, 1'b0);
        wait_done();
        check_eq("t7_fail", fail_cnt, 256);
        check_eq("t7_pass", pass_cnt, 0);

        // Async reset at vector 100.
        run_sweep(3'd2, 0, 0, 100, -1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_pass", pass_cnt, 0);
        check_eq("t5_rst_busy", {busy, done, bus.in_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_sweep(3'd1, 0, 0, 256, -1, 1'b0);
        wait_done();
        check_eq("t5_pass", pass_cnt, 256);

        // Signature repeatability and sensitivity.
        run_sweep(3'd5, 0, 0, 256, -1, 1'b0);
        wait_done();
        check_sig("t6_sig_a");
        sig_a = signature;
        run_sweep(3'd5, 0, 0, 256, -1, 1'b0);
        wait_done();
        check_sig("t6_sig_b");
        run_sweep(3'd5, 0, 0, 256, 10, 1'b0);
        wait_done();
        check_sig("t6_sig_flip");
        check_eq("t6_flip_fail", fail_cnt, 1);
`ifdef RESP_MISR_EN
        check_eq("t6_sig_differs", 32'(signature != sig_a), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
